// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, DATA_WIDTH data bits (LSB first), optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits; the default build sends one.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;
  logic [IW-1:0]           idx_nxt;
`ifdef UART_TX_TWO_STOP_EN
  logic                    stop2_q, stop2_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  assign idx_nxt = idx_q + 1'b1;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          // First pass through STOP only arms the second stop bit.
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d = 1'b0;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  assign TX_OUT  = tx_q;
  assign Busy    = busy_q;
  assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the stimulus pushes expected frames, a monitor checks
// the line bit by bit, the Busy length, the Tx_Done pulse and the idle gap between frames.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int EXTRA = (NSTOP - 1) * CPB;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          busy_len;
    bit          gap_chk;
  } frame_t;

  frame_t sb_q[$];

  logic          clk;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          Busy;
  logic          Tx_Done;

  int total;
  int bad;
  int cyc;
  bit mon_en;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .Tx_Done    (Tx_Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int t;
    t = 0;
    while (Busy !== lvl && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (Busy !== lvl) check(name, int'(Busy), int'(lvl));
  endtask

  // Builds the expected frame from hand-supplied parity and Busy length, then drives the request.
  task automatic issue(input logic [7:0] d, input logic pe, input logic pt, input logic par,
                       input bit gap, input bit hold, input int exp_len);
    frame_t f;
    int     nb;
    f.bits = '0;
    for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
    nb = DW + 1;
    if (pe) begin
      f.bits[nb] = par;
      nb++;
    end
    for (int s = 0; s < NSTOP; s++) begin
      f.bits[nb] = 1'b1;
      nb++;
    end
    f.nbits    = nb;
    f.busy_len = exp_len;
    f.gap_chk  = gap;
    sb_q.push_back(f);
    @(negedge clk);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    wait_level(1'b0, "wait_idle_timeout");
    wait_level(1'b1, "wait_busy_timeout");
    if (!hold) begin
      Data_Valid = 1'b0;
      P_DATA     = ~d;
      PAR_EN     = ~pe;
      PAR_TYP    = ~pt;
    end
  endtask

  // Monitor: pops one expected frame per rising Busy and checks it against the line.
  initial begin
    frame_t f;
    int     n;
    int     rise_cyc;
    int     fall_cyc;
    bit     ok;
    bit     done_pend;
    fall_cyc  = -100;
    done_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (done_pend) begin
        check("tx_done_one_cycle", int'(Tx_Done), 0);
        done_pend = 1'b0;
      end
      if (mon_en && Busy === 1'b1) begin
        rise_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("expected_frames_queued", sb_q.size(), 1);
          for (int t = 0; t < 400 && Busy === 1'b1; t++) @(negedge clk);
        end else begin
          f = sb_q.pop_front();
          if (f.gap_chk) check("idle_gap", rise_cyc - fall_cyc, 1);
          n = 0;
          for (int i = 0; i < f.nbits; i++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) begin
              if (i != 0 || k != 0) @(negedge clk);
              if (TX_OUT !== f.bits[i] || Tx_Done !== 1'b0) ok = 1'b0;
              if (Busy === 1'b1) n++;
            end
            check($sformatf("frame_bit%0d", i), int'(ok), 1);
          end
          @(negedge clk);
          check("busy_len", n, f.busy_len);
          check("busy_fall", int'(Busy), 0);
          check("tx_done_pulse", int'(Tx_Done), 1);
          check("line_idle_after_frame", int'(TX_OUT), 1);
          fall_cyc  = cyc;
          done_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    bit ok;
    total      = 0;
    bad        = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx_out", int'(TX_OUT), 1);
    check("reset_busy", int'(Busy), 0);
    check("reset_tx_done", int'(Tx_Done), 0);
    rst = 1'b0;

    // Abandon a frame mid-DATA with an asynchronous reset.
    @(negedge clk);
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    wait_level(1'b1, "reset_frame_busy_timeout");
    Data_Valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midframe_reset_tx_out", int'(TX_OUT), 1);
    check("midframe_reset_busy", int'(Busy), 0);
    check("midframe_reset_tx_done", int'(Tx_Done), 0);
    @(negedge clk);
    rst = 1'b0;
    ok  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Tx_Done !== 1'b0) ok = 1'b0;
    end
    check("post_reset_idle", int'(ok), 1);

    mon_en = 1'b1;

    // 0xA5 has four ones: even parity 0, odd parity 1.
    issue(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 44 + EXTRA);
    wait_level(1'b0, "frame_end_timeout");
    issue(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 44 + EXTRA);
    wait_level(1'b0, "frame_end_timeout");
    // 0x07 has three ones: even parity 1.
    issue(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 44 + EXTRA);
    wait_level(1'b0, "frame_end_timeout");
    // No parity slot.
    issue(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40 + EXTRA);
    wait_level(1'b0, "frame_end_timeout");

    // A request pulsed mid-frame must be dropped.
    issue(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40 + EXTRA);
    repeat (6) @(negedge clk);
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b1;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    wait_level(1'b0, "frame_end_timeout");
    repeat (5) @(negedge clk);

    // Back-to-back: request held across completion; inputs change while frame one is in flight.
    // 0x81 odd parity -> 1; 0x00 odd parity -> 1.
    issue(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 44 + EXTRA);
    issue(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 44 + EXTRA);
    wait_level(1'b0, "frame_end_timeout");

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
